// File: rtl/register_bridge.sv
// Byte-stream command decoder that masters the register bus: parses framed
// read/write commands from the UART receiver and returns framed responses.
module register_bridge #(
  parameter logic [7:0]  SYNC           = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        ipClk,
  input  logic        Reset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxValid,
  input  logic        ipTxReady,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  input  logic [31:0] ipRdData,
  output logic        opBusy
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, WRITE, RD_WAIT, RD_CAP, RESP
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        is_write_reg, is_write_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [2:0]  tx_idx_reg, tx_idx_next;
  logic [7:0]  rsp_code_reg, rsp_code_next;
  logic [31:0] rsp_data_reg, rsp_data_next;
  logic [7:0]  addr_reg, addr_next;
  logic [31:0] wr_data_reg, wr_data_next;
  logic [31:0] timer_reg, timer_next;
  logic [2:0]  rsp_last;
  logic [7:0]  tx_byte;

  // Read responses carry four data bytes, write/error responses only the code.
  assign rsp_last = (rsp_code_reg == 8'h00) ? 3'd5 : 3'd1;

  always_comb begin
    case (tx_idx_reg)
      3'd0:    tx_byte = SYNC;
      3'd1:    tx_byte = rsp_code_reg;
      3'd2:    tx_byte = rsp_data_reg[7:0];
      3'd3:    tx_byte = rsp_data_reg[15:8];
      3'd4:    tx_byte = rsp_data_reg[23:16];
      3'd5:    tx_byte = rsp_data_reg[31:24];
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    is_write_next = is_write_reg;
    byte_idx_next = byte_idx_reg;
    tx_idx_next   = tx_idx_reg;
    rsp_code_next = rsp_code_reg;
    rsp_data_next = rsp_data_reg;
    addr_next     = addr_reg;
    wr_data_next  = wr_data_reg;
    timer_next    = timer_reg;

    case (state_reg)
      IDLE: begin
        timer_next = 32'd0;
        if (ipRxValid && ipRxData == SYNC) state_next = CMD;
      end
      CMD, ADDR, DATA: begin
        if (ipRxValid) begin
          timer_next = 32'd0;
          case (state_reg)
            CMD: begin
              if (ipRxData == 8'h00 || ipRxData == 8'h01) begin
                is_write_next = ipRxData[0];
                state_next    = ADDR;
              end else begin
                rsp_code_next = 8'hFF;
                tx_idx_next   = 3'd0;
                state_next    = RESP;
              end
            end
            ADDR: begin
              addr_next     = ipRxData;
              byte_idx_next = 2'd0;
              state_next    = is_write_reg ? DATA : RD_WAIT;
            end
            default: begin
              wr_data_next[8*byte_idx_reg +: 8] = ipRxData;
              byte_idx_next = byte_idx_reg + 2'd1;
              if (byte_idx_reg == 2'd3) state_next = WRITE;
            end
          endcase
        end else if (timer_reg == TIMEOUT_LAST) begin
          // Stalled frame: drop it without touching the bus or replying.
          timer_next    = 32'd0;
          byte_idx_next = 2'd0;
          state_next    = IDLE;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end
      WRITE: begin
        rsp_code_next = 8'h01;
        tx_idx_next   = 3'd0;
        state_next    = RESP;
      end
      RD_WAIT: state_next = RD_CAP;
      RD_CAP: begin
        rsp_data_next = ipRdData;
        rsp_code_next = 8'h00;
        tx_idx_next   = 3'd0;
        state_next    = RESP;
      end
      RESP: begin
        if (ipTxReady) begin
          if (tx_idx_reg == rsp_last) begin
            tx_idx_next = 3'd0;
            state_next  = IDLE;
          end else begin
            tx_idx_next = tx_idx_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      is_write_reg <= 1'b0;
      byte_idx_reg <= 2'd0;
      tx_idx_reg   <= 3'd0;
      rsp_code_reg <= 8'h00;
      rsp_data_reg <= 32'd0;
      addr_reg     <= 8'h00;
      wr_data_reg  <= 32'd0;
      timer_reg    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      is_write_reg <= is_write_next;
      byte_idx_reg <= byte_idx_next;
      tx_idx_reg   <= tx_idx_next;
      rsp_code_reg <= rsp_code_next;
      rsp_data_reg <= rsp_data_next;
      addr_reg     <= addr_next;
      wr_data_reg  <= wr_data_next;
      timer_reg    <= timer_next;
    end
  end

  assign opAddress  = addr_reg;
  assign opWrData   = wr_data_reg;
  assign opWrEnable = (state_reg == WRITE);
  assign opTxValid  = (state_reg == RESP);
  assign opTxData   = (state_reg == RESP) ? tx_byte : 8'h00;
  assign opBusy     = (state_reg != IDLE);

endmodule

// File: tb/tb_register_bridge.sv
// Directed self-checking bench for register_bridge with a registered-read
// register file model and a negedge transfer monitor.
module tb_register_bridge;

  logic        ipClk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  ipRxData = 8'h00;
  logic        ipRxValid = 1'b0;
  logic [7:0]  opTxData;
  logic        opTxValid;
  logic        ipTxReady = 1'b1;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic [31:0] ipRdData = 32'd0;
  logic        opBusy;

  int n_checks = 0;
  int n_fails  = 0;
  int wr_count = 0;
  logic [7:0]  wr_addr_seen = 8'h00;
  logic [31:0] wr_data_seen = 32'd0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_b[6];

  register_bridge #(.SYNC(8'h55), .TIMEOUT_CYCLES(16)) dut (
    .ipClk(ipClk), .Reset(Reset), .ipRxData(ipRxData), .ipRxValid(ipRxValid),
    .opTxData(opTxData), .opTxValid(opTxValid), .ipTxReady(ipTxReady),
    .opAddress(opAddress), .opWrData(opWrData), .opWrEnable(opWrEnable),
    .ipRdData(ipRdData), .opBusy(opBusy)
  );

  always #5 ipClk = ~ipClk;

  // Register file model: one-cycle registered read.
  always @(posedge ipClk)
    ipRdData <= (opAddress == 8'h03) ? 32'hCAFE0004 : {24'hDEAD00, opAddress};

  always @(negedge ipClk) begin
    if (opTxValid && ipTxReady) rx_q.push_back(opTxData);
    if (opWrEnable) begin
      wr_count++;
      wr_addr_seen = opAddress;
      wr_data_seen = opWrData;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    ipRxData  = b;
    ipRxValid = 1'b1;
    @(posedge ipClk); #1;
    ipRxValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge ipClk); #1; end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    idle(3);
    n_checks++; if (opTxData !== 8'h00) begin n_fails++; $display("FAIL reset_txdata got %h want 00", opTxData); end
    n_checks++; if (opTxValid !== 1'b0) begin n_fails++; $display("FAIL reset_txvalid got %b want 0", opTxValid); end
    n_checks++; if (opAddress !== 8'h00) begin n_fails++; $display("FAIL reset_address got %h want 00", opAddress); end
    n_checks++; if (opWrData !== 32'd0) begin n_fails++; $display("FAIL reset_wrdata got %h want 0", opWrData); end
    n_checks++; if (opWrEnable !== 1'b0) begin n_fails++; $display("FAIL reset_wren got %b want 0", opWrEnable); end
    n_checks++; if (opBusy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %b want 0", opBusy); end
    Reset = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_write;
    int w0;
    ipTxReady = 1'b1;
    rx_q.delete();
    w0 = wr_count;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    // Cycle after D3: write strobe with stable address/data
    n_checks++; if (opWrEnable !== 1'b1) begin n_fails++; $display("FAIL write_strobe got %b want 1", opWrEnable); end
    n_checks++; if (opAddress !== 8'h02) begin n_fails++; $display("FAIL write_addr got %h want 02", opAddress); end
    n_checks++; if (opWrData !== 32'h12345678) begin n_fails++; $display("FAIL write_data got %h want 12345678", opWrData); end
    idle(1);
    n_checks++; if (opWrEnable !== 1'b0) begin n_fails++; $display("FAIL write_strobe_len got %b want 0", opWrEnable); end
    n_checks++; if (opTxValid !== 1'b1 || opTxData !== 8'h55) begin n_fails++; $display("FAIL write_rsp_start got v=%b d=%h want v=1 d=55", opTxValid, opTxData); end
    for (int i = 0; i < 20 && (opBusy || rx_q.size() < 2); i++) idle(1);
    exp_b = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    n_checks++; if (rx_q.size() != 2) begin n_fails++; $display("FAIL write_rsp_len got %0d want 2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_b[i]) begin n_fails++; $display("FAIL write_rsp_byte%0d got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    n_checks++; if (wr_count - w0 != 1) begin n_fails++; $display("FAIL write_count got %0d want 1", wr_count - w0); end
    n_checks++; if (opAddress !== 8'h02 || opWrData !== 32'h12345678) begin n_fails++; $display("FAIL write_hold got %h/%h want 02/12345678", opAddress, opWrData); end
    $display("write addr=%h data=%h rsp_bytes=%0d", wr_addr_seen, wr_data_seen, rx_q.size());
  endtask

  task automatic test_read(input string tag);
    int w0;
    rx_q.delete();
    w0 = wr_count;
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h03);
    n_checks++; if (opAddress !== 8'h03) begin n_fails++; $display("FAIL %s_addr got %h want 03", tag, opAddress); end
    idle(1);
    n_checks++; if (opTxValid !== 1'b0) begin n_fails++; $display("FAIL %s_early_valid got %b want 0", tag, opTxValid); end
    idle(1);
    n_checks++; if (opTxValid !== 1'b1 || opTxData !== 8'h55) begin n_fails++; $display("FAIL %s_rsp_start got v=%b d=%h want v=1 d=55", tag, opTxValid, opTxData); end
    for (int i = 0; i < 20 && (opBusy || rx_q.size() < 6); i++) idle(1);
    exp_b = '{8'h55, 8'h00, 8'h04, 8'h00, 8'hFE, 8'hCA};
    n_checks++; if (rx_q.size() != 6) begin n_fails++; $display("FAIL %s_rsp_len got %0d want 6", tag, rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_b[i]) begin n_fails++; $display("FAIL %s_rsp_byte%0d got %h want %h", tag, i, rx_q[i], exp_b[i]); end
    end
    n_checks++; if (wr_count != w0) begin n_fails++; $display("FAIL %s_no_write got %0d want 0", tag, wr_count - w0); end
    $display("read addr=03 rsp_bytes=%0d", rx_q.size());
  endtask

  task automatic test_error;
    int w0;
    rx_q.delete();
    w0 = wr_count;
    send_byte(8'h00);
    n_checks++; if (opBusy !== 1'b0) begin n_fails++; $display("FAIL hunt_00 busy got %b want 0", opBusy); end
    send_byte(8'hAA);
    n_checks++; if (opBusy !== 1'b0) begin n_fails++; $display("FAIL hunt_aa busy got %b want 0", opBusy); end
    send_byte(8'h55);
    send_byte(8'h07);
    n_checks++; if (opTxValid !== 1'b1 || opTxData !== 8'h55) begin n_fails++; $display("FAIL error_rsp_start got v=%b d=%h want v=1 d=55", opTxValid, opTxData); end
    for (int i = 0; i < 20 && (opBusy || rx_q.size() < 2); i++) idle(1);
    exp_b = '{8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    n_checks++; if (rx_q.size() != 2) begin n_fails++; $display("FAIL error_rsp_len got %0d want 2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_b[i]) begin n_fails++; $display("FAIL error_rsp_byte%0d got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    n_checks++; if (wr_count != w0) begin n_fails++; $display("FAIL error_no_write got %0d want 0", wr_count - w0); end
    $display("error cmd=07 rsp_bytes=%0d", rx_q.size());
  endtask

  task automatic test_back_pressure;
    logic       pat[4];
    logic       stalled;
    logic [7:0] prev;
    int         k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rx_q.delete();
    ipTxReady = 1'b0;
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h03);
    stalled = 1'b0;
    prev = 8'h00;
    for (k = 0; k < 60; k++) begin
      ipTxReady = pat[k % 4];
      if (stalled && opTxValid) begin
        n_checks++; if (opTxData !== prev) begin n_fails++; $display("FAIL bp_stable cyc%0d got %h want %h", k, opTxData, prev); end
      end
      stalled = opTxValid && !ipTxReady;
      prev = opTxData;
      if (!opBusy && rx_q.size() >= 6) break;
      idle(1);
    end
    ipTxReady = 1'b1;
    n_checks++; if (k >= 60) begin n_fails++; $display("FAIL bp_timeout got busy=%b want 0", opBusy); end
    exp_b = '{8'h55, 8'h00, 8'h04, 8'h00, 8'hFE, 8'hCA};
    n_checks++; if (rx_q.size() != 6) begin n_fails++; $display("FAIL bp_rsp_len got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_b[i]) begin n_fails++; $display("FAIL bp_rsp_byte%0d got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    $display("read with back-pressure rsp_bytes=%0d", rx_q.size());
  endtask

  task automatic test_timeout;
    int w0;
    rx_q.delete();
    w0 = wr_count;
    // Gaps under the limit must not abort: each byte restarts the counter.
    send_byte(8'h55); idle(10);
    send_byte(8'h01); idle(10);
    send_byte(8'h02); idle(10);
    n_checks++; if (opBusy !== 1'b1) begin n_fails++; $display("FAIL to_gap_busy got %b want 1", opBusy); end
    send_byte(8'h78);
    idle(8);
    n_checks++; if (opBusy !== 1'b1) begin n_fails++; $display("FAIL to_early_busy got %b want 1", opBusy); end
    idle(12);
    n_checks++; if (opBusy !== 1'b0) begin n_fails++; $display("FAIL to_abort_busy got %b want 0", opBusy); end
    n_checks++; if (wr_count != w0 || rx_q.size() != 0) begin n_fails++; $display("FAIL to_silent got writes=%0d bytes=%0d want 0/0", wr_count - w0, rx_q.size()); end
    $display("timeout frame abandoned");
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h05);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    for (int i = 0; i < 20 && (opBusy || rx_q.size() < 2); i++) idle(1);
    n_checks++; if (wr_count - w0 != 1) begin n_fails++; $display("FAIL to_next_count got %0d want 1", wr_count - w0); end
    n_checks++; if (wr_addr_seen !== 8'h05 || wr_data_seen !== 32'hDEADBEEF) begin n_fails++; $display("FAIL to_next_write got %h/%h want 05/deadbeef", wr_addr_seen, wr_data_seen); end
    n_checks++; if (rx_q.size() != 2) begin n_fails++; $display("FAIL to_next_rsp_len got %0d want 2", rx_q.size()); end
    $display("write addr=%h data=%h after timeout", wr_addr_seen, wr_data_seen);
  endtask

  task automatic test_reset_mid_write;
    int w0;
    rx_q.delete();
    w0 = wr_count;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'h78);
    Reset = 1'b1;
    idle(1);
    n_checks++; if (opBusy !== 1'b0 || opTxValid !== 1'b0 || opTxData !== 8'h00) begin n_fails++; $display("FAIL mid_rst_ctrl got busy=%b v=%b d=%h want 0/0/00", opBusy, opTxValid, opTxData); end
    n_checks++; if (opAddress !== 8'h00 || opWrData !== 32'd0 || opWrEnable !== 1'b0) begin n_fails++; $display("FAIL mid_rst_bus got %h/%h/%b want 00/0/0", opAddress, opWrData, opWrEnable); end
    Reset = 1'b0;
    idle(2);
    n_checks++; if (wr_count != w0) begin n_fails++; $display("FAIL mid_rst_no_write got %0d want 0", wr_count - w0); end
    $display("reset during write frame");
    test_read("post_rst_read");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read("read");
    test_error();
    test_back_pressure();
    test_timeout();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/register_bridge.md
# register_bridge

Byte-stream command decoder that acts as the initiator of the memory-mapped register bus. It parses framed read/write commands arriving from the UART receiver and drives address, write data and write enable into the register file. It captures read data and returns framed responses to the UART transmitter. It sits between the UART byte interfaces and the register file, the only bus master in the design.

## Interface
- SYNC, 8'h55, frame start byte; also the first byte of every response.
- TIMEOUT_CYCLES, 50_000_000, idle ipClk cycles allowed between bytes of one command frame before abort (counter 32 bits).
- ipClk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ipRxData  input  8  received byte.
- ipRxValid  input  1  single-cycle strobe: ipRxData valid this cycle; no back-pressure.
- opTxData  output  8  response byte.
- opTxValid  output  1  opTxData valid; transfer when opTxValid && ipTxReady.
- ipTxReady  input  1  transmitter can accept a byte.
- opAddress  output  8  register bus address.
- opWrData  output  32  register bus write data.
- opWrEnable  output  1  register bus write strobe, one cycle per write.
- ipRdData  input  32  register bus read data; valid one cycle after the address is presented (registered read).
- opBusy  output  1  high in every state except IDLE.

## Operation
- Command frame: SYNC, CMD, ADDR, then for writes D0..D3 (little-endian, D0 = bits 7:0).
- CMD 8'h00 = read, 8'h01 = write, anything else = error.
- Responses (all sent via valid/ready):
  - Read: SYNC, 8'h00, R0..R3 (6 bytes, little-endian).
  - Write: SYNC, 8'h01 (2 bytes).
  - Error: SYNC, 8'hFF (2 bytes).
- States and transitions:
  - IDLE: a byte equal to SYNC -> CMD; any other byte is discarded.
  - CMD: 00/01 -> ADDR, latching the command; other value -> RESP with the error response.
  - ADDR: latch opAddress; a read -> RD_WAIT; a write -> DATA with byte index 0.
  - DATA: shift each byte into opWrData[8i+7:8i]; after D3 -> WRITE.
  - WRITE: opWrEnable=1 for exactly this cycle -> RESP.
  - RD_WAIT: one cycle -> RD_CAP.
  - RD_CAP: latch ipRdData into the response buffer -> RESP.
  - RESP: present the buffered bytes in order. Advance only when opTxValid && ipTxReady. After the last byte is accepted, drop opTxValid -> IDLE.
- A byte equal to SYNC inside CMD/ADDR/DATA is treated as data, not a resync.
- Bytes arriving while in WRITE, RD_WAIT, RD_CAP or RESP are dropped silently.
- Timeout:
  - The counter is cleared on every accepted byte and counts while in CMD, ADDR or DATA.
  - When it reaches TIMEOUT_CYCLES, the frame is abandoned -> IDLE, with no bus access and no response.
- opAddress and opWrData hold their last values after a transaction; only opWrEnable is strobed.

## Timing
- Reset values:
  - opTxData=0, opTxValid=0, opAddress=0, opWrData=0, opWrEnable=0, opBusy=0.
  - State IDLE; timeout counter 0; byte index 0.
- Reset during any state aborts immediately. A write is issued only if the WRITE cycle has already occurred; any partial response is discarded.
- Write: D3 strobed in cycle T -> opWrEnable=1 in cycle T+1 with opAddress/opWrData stable since ≤T+1 -> opTxValid=1 with SYNC from cycle T+2.
- Read: ADDR strobed in cycle T -> opAddress valid from T+1 -> ipRdData sampled at the end of T+2 -> opTxValid=1 with SYNC from T+3.
- Error: bad CMD strobed in cycle T -> opTxValid=1 from T+1.
- opTxData must stay stable while opTxValid=1 and ipTxReady=0.
- Next byte is presented the cycle after an accepted transfer; back-to-back bytes are allowed when ipTxReady is held high.
- The first byte of a new frame is accepted in the cycle IDLE is re-entered.

## Test plan
- Write: bytes 55,01,02,78,56,34,12 -> one opWrEnable pulse with opAddress=02, opWrData=32'h12345678, at the cycle after the last byte; response 55,01.
- Read: bytes 55,00,03 with ipRdData=32'hCAFE0004 one cycle after the address -> response 55,00,04,00,FE,CA; opWrEnable never asserted.
- Error and sync hunting: bytes 00,AA,55,07 -> first two bytes ignored; response 55,FF; no bus write.
- Back-pressure: read response with ipTxReady toggling 1,0,0,1,... -> opTxData unchanged while stalled, all 6 bytes delivered exactly once in order.
- Timeout (TIMEOUT_CYCLES=16): 55,01,02,78 then 16 idle cycles -> return to IDLE, opBusy=0, no write, no response. A following full write frame completes normally.
- Reset mid-write: Reset after 55,01,02,78 -> all outputs at reset values next cycle; no opWrEnable. A subsequent read frame works.
